bram_access_ctrl: RTL

//   Command sequencer in the 65 MHz domain, directly upstream of the 256x8 BRAM block.

---
 rtl/bram_access_ctrl_if.sv | 51 +++++
 rtl/bram_access_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/bram_access_ctrl_if.sv
// Command, response and BRAM strobe bundle for bram_access_ctrl.
// slave = controller side, master = requester/BRAM side.
interface bram_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [7:0]        cmd_len;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_op_done;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_wdata, cmd_len,
    output cmd_ready,
    output rsp_valid, rsp_addr, rsp_data,
    output rsp_last, rsp_err,
    input  rsp_ready,
    output mem_addr, mem_wdata,
    output mem_wr_en, mem_rd_en,
    input  mem_rdata, mem_op_done
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_wdata, cmd_len,
    input  cmd_ready,
    input  rsp_valid, rsp_addr, rsp_data,
    input  rsp_last, rsp_err,
    output rsp_ready,
    input  mem_addr, mem_wdata,
    input  mem_wr_en, mem_rd_en,
    output mem_rdata, mem_op_done
  );
endinterface

// File: rtl/bram_access_ctrl.sv
// BRAM command sequencer: single writes, wrapping burst reads,
// op_done wait with timeout, one registered response beat per access.
module bram_access_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_access_ctrl_if.slave   bus,
  output logic                busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        beats_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              tmo;

  assign addr_d = addr_q + 1'b1;
  assign cnt_d  = cnt_q + 1'b1;
  assign tmo    = (cnt_d == CNT_W'(TIMEOUT));

  // Sequencer FSM; every output is a register set on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      beats_q       <= '0;
      cnt_q         <= '0;
      busy          <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_addr  <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_last  <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wr_en <= 1'b0;
      bus.mem_rd_en <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            wr_q          <= bus.cmd_write;
            addr_q        <= bus.cmd_addr;
            wdata_q       <= bus.cmd_wdata;
            beats_q       <= bus.cmd_len;
            bus.mem_addr  <= bus.cmd_addr;
            bus.mem_wdata <= bus.cmd_wdata;
            bus.mem_wr_en <= bus.cmd_write;
            bus.mem_rd_en <= !bus.cmd_write;
            bus.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.mem_wr_en <= 1'b0;
          bus.mem_rd_en <= 1'b0;
          cnt_q         <= '0;
          state_q       <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (bus.mem_op_done) begin
            bus.rsp_data  <= wr_q ? wdata_q : bus.mem_rdata;
            bus.rsp_addr  <= addr_q;
            bus.rsp_err   <= 1'b0;
            bus.rsp_last  <= wr_q || (beats_q == 8'd0);
            bus.rsp_valid <= 1'b1;
            state_q       <= S_RESP;
          end else if (tmo) begin
            bus.rsp_data  <= '0;
            bus.rsp_addr  <= addr_q;
            bus.rsp_err   <= 1'b1;
            bus.rsp_last  <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state_q       <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (bus.rsp_last) begin
              bus.cmd_ready <= 1'b1;
              busy          <= 1'b0;
              state_q       <= S_IDLE;
            end else begin
              addr_q        <= addr_d;
              beats_q       <= beats_q - 8'd1;
              bus.mem_addr  <= addr_d;
              bus.mem_rd_en <= 1'b1;
              state_q       <= S_ISSUE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
